pad_coincidence_trigger: RTL and testbench

Sits directly downstream of the per-layer pad data selectors. Each selector delivers one registered pad bit per layer into this block. The block stretches each layer's rising edge into a programmable coincidence window and fires a trigger when the number of simultaneously active layers reaches a programmable majority. It then presents a BCID-stamped trigger record on a valid/ready interface and enforces a programmable deadtime before re-arming.

---
 rtl/pad_coincidence_trigger.sv | 233 +++++++++++++++++++++++
 tb/tb_pad_coincidence_trigger.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_coincidence_trigger.sv
`default_nettype none
// ============================================================================
// pad_coincidence_trigger : stretched-edge majority trigger with BCID stamping
// Revision 1.0
// ============================================================================
module pad_coincidence_trigger #(
  parameter int NUM_LAYER  = 8,
  parameter int BCID_WIDTH = 12,
  parameter int WIN_WIDTH  = 4,
  parameter int DEAD_WIDTH = 8,
  parameter int MAJ_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [NUM_LAYER-1:0]  pad_hit,
  input  logic [WIN_WIDTH-1:0]  coinc_window,
  input  logic [MAJ_WIDTH-1:0]  majority,
  input  logic [DEAD_WIDTH-1:0] deadtime,
  input  logic                  trig_ready,
  output logic                  trig_valid,
  output logic [BCID_WIDTH-1:0] trig_bcid,
  output logic [NUM_LAYER-1:0]  trig_layer_mask,
  output logic [15:0]           trig_count,
  output logic [7:0]            missed_count,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_HOLD  = 2'd2,
    S_DEAD  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DEAD_WIDTH-1:0] dead_q, dead_d;

  logic [BCID_WIDTH-1:0] bcid_cnt_q;
  logic [BCID_WIDTH-1:0] bcid_q;
  logic [NUM_LAYER-1:0]  hit_q;
  logic [NUM_LAYER-1:0]  hit_qd;
  logic [NUM_LAYER-1:0]  rise;
  logic                  raw_coinc_q;

  logic [NUM_LAYER-1:0]  active;
  logic [BCID_WIDTH-1:0] edge_bcid [NUM_LAYER];
  logic [BCID_WIDTH-1:0] stamp_sel;

  logic                  coinc_q;
  logic [NUM_LAYER-1:0]  mask_q;
  logic [BCID_WIDTH-1:0] stamp_q;

  logic [BCID_WIDTH-1:0] trig_bcid_q;
  logic [NUM_LAYER-1:0]  trig_mask_q;
  logic [15:0]           trig_count_q;
  logic [7:0]            missed_q;

  logic [WIN_WIDTH-1:0]  win_eff;
  logic [MAJ_WIDTH-1:0]  maj_eff;
  logic                  coinc;
  logic                  raw_coinc;
  logic                  armed;
  logic                  clear_str;
  logic                  fire;
  logic                  xfer;

  function automatic logic [MAJ_WIDTH-1:0] popcnt(input logic [NUM_LAYER-1:0] v);
    logic [MAJ_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_LAYER; i++) begin
      n = n + MAJ_WIDTH'(v[i]);
    end
    return n;
  endfunction

  assign win_eff   = (coinc_window == '0) ? WIN_WIDTH'(1) : coinc_window;
  assign maj_eff   = (majority == '0) ? MAJ_WIDTH'(1) : majority;
  assign rise      = hit_q & ~hit_qd;
  assign coinc     = (popcnt(active) >= maj_eff);
  assign raw_coinc = (popcnt(hit_q) >= maj_eff);
  assign armed     = (state_q == S_ARMED);
  assign fire      = enable & armed & coinc_q;
  assign xfer      = (state_q == S_HOLD) & trig_ready;
  assign clear_str = (state_q == S_IDLE) | ~enable | xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcid_cnt_q  <= '0;
      bcid_q      <= '0;
      hit_q       <= '0;
      hit_qd      <= '0;
      raw_coinc_q <= 1'b0;
    end else begin
      bcid_cnt_q  <= bcid_cnt_q + BCID_WIDTH'(1);
      bcid_q      <= bcid_cnt_q;
      hit_q       <= pad_hit;
      hit_qd      <= hit_q;
      raw_coinc_q <= raw_coinc;
    end
  end

  // One stretch counter plus the BCID of its most recent load per layer
  generate
    for (genvar gi = 0; gi < NUM_LAYER; gi++) begin : g_layer
      logic [WIN_WIDTH-1:0]  str_q, str_d;
      logic [BCID_WIDTH-1:0] ebcid_q, ebcid_d;

      always_comb begin
        str_d   = str_q;
        ebcid_d = ebcid_q;
        if (clear_str) begin
          str_d = '0;
        end else if (armed && rise[gi]) begin
          str_d   = win_eff;
          ebcid_d = bcid_q;
        end else if (str_q != '0) begin
          str_d = str_q - WIN_WIDTH'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          str_q   <= '0;
          ebcid_q <= '0;
        end else begin
          str_q   <= str_d;
          ebcid_q <= ebcid_d;
        end
      end

      assign active[gi]    = (str_q != '0);
      assign edge_bcid[gi] = ebcid_q;
    end
  endgenerate

  // Youngest load wins; ages stay far below the BCID period so modulo distance is safe
  always_comb begin
    logic                  found;
    logic [BCID_WIDTH-1:0] best_age;
    logic [BCID_WIDTH-1:0] age;
    found     = 1'b0;
    best_age  = '0;
    age       = '0;
    stamp_sel = '0;
    for (int i = 0; i < NUM_LAYER; i++) begin
      age = bcid_q - edge_bcid[i];
      if (active[i] && (!found || (age < best_age))) begin
        found     = 1'b1;
        best_age  = age;
        stamp_sel = edge_bcid[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coinc_q <= 1'b0;
      mask_q  <= '0;
      stamp_q <= '0;
    end else begin
      coinc_q <= coinc & enable & armed;
      mask_q  <= active;
      stamp_q <= stamp_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dead_q  <= '0;
    end else begin
      state_q <= state_d;
      dead_q  <= dead_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dead_d  = dead_q;
    if (!enable) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_ARMED;
        S_ARMED: if (coinc_q) state_d = S_HOLD;
        S_HOLD: begin
          if (trig_ready) begin
            if (deadtime != '0) begin
              state_d = S_DEAD;
              dead_d  = deadtime;
            end else begin
              state_d = S_ARMED;
            end
          end
        end
        S_DEAD: begin
          if (dead_q <= DEAD_WIDTH'(1)) state_d = S_ARMED;
          else                          dead_d  = dead_q - DEAD_WIDTH'(1);
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_bcid_q  <= '0;
      trig_mask_q  <= '0;
      trig_count_q <= '0;
      missed_q     <= '0;
    end else begin
      if (fire) begin
        trig_bcid_q <= stamp_q;
        trig_mask_q <= mask_q;
      end
      if (xfer) trig_count_q <= trig_count_q + 16'd1;
      if (((state_q == S_HOLD) || (state_q == S_DEAD)) && raw_coinc && !raw_coinc_q
          && (missed_q != 8'hFF)) begin
        missed_q <= missed_q + 8'd1;
      end
    end
  end

  assign trig_valid      = (state_q == S_HOLD);
  assign busy            = (state_q == S_HOLD) || (state_q == S_DEAD);
  assign trig_bcid       = trig_bcid_q;
  assign trig_layer_mask = trig_mask_q;
  assign trig_count      = trig_count_q;
  assign missed_count    = missed_q;

endmodule
`default_nettype wire

// File: tb/tb_pad_coincidence_trigger.sv
`default_nettype none
// ============================================================================
// tb_pad_coincidence_trigger : vector table, directed corners, random vs model
// Revision 1.0
// ============================================================================
module tb_pad_coincidence_trigger;
  localparam int NL = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  pad_hit = '0;
  logic [3:0]  coinc_window = '0;
  logic [3:0]  majority = '0;
  logic [7:0]  deadtime = '0;
  logic        trig_ready = 1'b0;
  logic        trig_valid;
  logic [11:0] trig_bcid;
  logic [7:0]  trig_layer_mask;
  logic [15:0] trig_count;
  logic [7:0]  missed_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pad_coincidence_trigger dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .enable          (enable),
    .pad_hit         (pad_hit),
    .coinc_window    (coinc_window),
    .majority        (majority),
    .deadtime        (deadtime),
    .trig_ready      (trig_ready),
    .trig_valid      (trig_valid),
    .trig_bcid       (trig_bcid),
    .trig_layer_mask (trig_layer_mask),
    .trig_count      (trig_count),
    .missed_count    (missed_count),
    .busy            (busy)
  );

  // Reference model: layers tracked by load timestamp, modes 0 idle/1 armed/2 hold/3 dead
  int          m_mode, m_t, m_dl, m_missed;
  int          m_lt [NL];
  int          m_lw [NL];
  logic [11:0] m_eb [NL];
  logic [7:0]  m_h1, m_h2, m_maskq, m_omask;
  logic [11:0] m_bq, m_bcid, m_stampq, m_obcid;
  logic        m_cq, m_rawq;
  logic [15:0] m_cnt;

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_dl = 0; m_missed = 0;
    for (int i = 0; i < NL; i++) begin
      m_lt[i] = -1000; m_lw[i] = 0; m_eb[i] = '0;
    end
    m_h1 = '0; m_h2 = '0; m_maskq = '0; m_omask = '0;
    m_bq = '0; m_bcid = '0; m_stampq = '0; m_obcid = '0;
    m_cq = 1'b0; m_rawq = 1'b0; m_cnt = '0;
  endtask

  task automatic model_edge();
    int          effw, effm, best, nmode, ndl;
    logic [7:0]  act, rise;
    logic [11:0] stamp;
    logic        raw, coinc, clr;
    effw = (coinc_window == 0) ? 1 : int'(coinc_window);
    effm = (majority == 0) ? 1 : int'(majority);
    best = -1;
    for (int i = 0; i < NL; i++) begin
      act[i] = (m_t - m_lt[i]) < m_lw[i];
      if (act[i] && (best < 0 || m_lt[i] > m_lt[best])) best = i;
    end
    stamp = (best >= 0) ? m_eb[best] : 12'd0;
    rise  = m_h1 & ~m_h2;
    raw   = $countones(m_h1) >= effm;
    coinc = $countones(act) >= effm;
    clr   = (m_mode == 0) || !enable || (m_mode == 2 && trig_ready);
    for (int i = 0; i < NL; i++) begin
      if (clr) m_lt[i] = -1000;
      else if (m_mode == 1 && rise[i]) begin
        m_lt[i] = m_t + 1; m_lw[i] = effw; m_eb[i] = m_bq;
      end
    end
    if ((m_mode == 2 || m_mode == 3) && raw && !m_rawq && m_missed < 255) m_missed++;
    if (m_mode == 2 && trig_ready) m_cnt++;
    nmode = m_mode; ndl = m_dl;
    if (!enable) nmode = 0;
    else begin
      case (m_mode)
        0: nmode = 1;
        1: if (m_cq) begin nmode = 2; m_obcid = m_stampq; m_omask = m_maskq; end
        2: if (trig_ready) begin
             if (deadtime != 0) begin nmode = 3; ndl = int'(deadtime); end
             else nmode = 1;
           end
        default: if (m_dl <= 1) nmode = 1; else ndl = m_dl - 1;
      endcase
    end
    m_cq = coinc && (m_mode == 1) && enable;
    m_maskq = act; m_stampq = stamp;
    m_mode = nmode; m_dl = ndl; m_rawq = raw;
    m_h2 = m_h1; m_h1 = pad_hit; m_bq = m_bcid; m_bcid = m_bcid + 12'd1; m_t++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m_valid", {31'd0, trig_valid}, {31'd0, m_mode == 2});
    chk("m_busy", {31'd0, busy}, {31'd0, m_mode >= 2});
    chk("m_bcid", {20'd0, trig_bcid}, {20'd0, m_obcid});
    chk("m_mask", {24'd0, trig_layer_mask}, {24'd0, m_omask});
    chk("m_count", {16'd0, trig_count}, {16'd0, m_cnt});
    chk("m_missed", {24'd0, missed_count}, m_missed);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; enable = 1'b0; pad_hit = '0; trig_ready = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [3:0] win;
    logic [3:0] maj;
    logic [7:0] pa;
    int         gap;
    logic [7:0] pb;
    logic       trig;
    logic [7:0] mask;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic       seen;
    logic [7:0] gotmask;

    tbl[0] = '{4'd4,  4'd1, 8'h08, 0,  8'h00, 1'b1, 8'h08};
    tbl[1] = '{4'd2,  4'd3, 8'h03, 1,  8'h04, 1'b1, 8'h07};
    tbl[2] = '{4'd2,  4'd3, 8'h03, 2,  8'h04, 1'b0, 8'h00};
    tbl[3] = '{4'd0,  4'd2, 8'h01, 1,  8'h02, 1'b0, 8'h00};
    tbl[4] = '{4'd0,  4'd2, 8'h03, 0,  8'h00, 1'b1, 8'h03};
    tbl[5] = '{4'd3,  4'd0, 8'h80, 0,  8'h00, 1'b1, 8'h80};
    tbl[6] = '{4'd4,  4'd9, 8'hFF, 0,  8'h00, 1'b0, 8'h00};
    tbl[7] = '{4'd3,  4'd8, 8'hF0, 2,  8'h0F, 1'b1, 8'hFF};
    tbl[8] = '{4'd15, 4'd2, 8'h10, 14, 8'h20, 1'b1, 8'h30};
    tbl[9] = '{4'd15, 4'd2, 8'h10, 15, 8'h20, 1'b0, 8'h00};

    // Reset state
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, trig_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_bcid", {20'd0, trig_bcid}, 32'd0);
    chk("rst_mask", {24'd0, trig_layer_mask}, 32'd0);
    chk("rst_count", {16'd0, trig_count}, 32'd0);
    chk("rst_missed", {24'd0, missed_count}, 32'd0);

    // Latency and stamping of a single-layer hit sampled at bcid 10
    do_reset();
    enable = 1'b1; coinc_window = 4'd4; majority = 4'd1; deadtime = 8'd0; trig_ready = 1'b1;
    repeat (10) cycle();
    pad_hit = 8'h08; cycle(); pad_hit = '0;
    cycle(); cycle();
    chk("lat_early", {31'd0, trig_valid}, 32'd0);
    cycle();
    chk("lat_valid", {31'd0, trig_valid}, 32'd1);
    chk("lat_bcid", {20'd0, trig_bcid}, 32'd10);
    chk("lat_mask", {24'd0, trig_layer_mask}, 32'h08);
    cycle();
    chk("lat_onecycle", {31'd0, trig_valid}, 32'd0);
    chk("lat_count", {16'd0, trig_count}, 32'd1);

    // Vector table
    do_reset();
    enable = 1'b1; deadtime = 8'd0; trig_ready = 1'b1;
    repeat (3) cycle();
    for (int r = 0; r < 10; r++) begin
      coinc_window = tbl[r].win; majority = tbl[r].maj;
      seen = 1'b0; gotmask = '0;
      for (int c = 0; c < tbl[r].gap + 14; c++) begin
        pad_hit = ((c == 0) ? tbl[r].pa : 8'h00) | ((c == tbl[r].gap) ? tbl[r].pb : 8'h00);
        cycle();
        if (trig_valid && !seen) begin seen = 1'b1; gotmask = trig_layer_mask; end
      end
      pad_hit = '0;
      repeat (20) cycle();
      chk($sformatf("tbl%0d_trig", r), {31'd0, seen}, {31'd0, tbl[r].trig});
      if (tbl[r].trig) chk($sformatf("tbl%0d_mask", r), {24'd0, gotmask}, {24'd0, tbl[r].mask});
    end

    // Backpressure: record stable while held, extra coincidence counted as missed
    do_reset();
    enable = 1'b1; coinc_window = 4'd4; majority = 4'd1; deadtime = 8'd0; trig_ready = 1'b0;
    repeat (5) cycle();
    pad_hit = 8'h01; cycle(); pad_hit = '0;
    repeat (3) cycle();
    for (int c = 0; c < 5; c++) begin
      chk("hold_valid", {31'd0, trig_valid}, 32'd1);
      chk("hold_bcid", {20'd0, trig_bcid}, 32'd5);
      chk("hold_mask", {24'd0, trig_layer_mask}, 32'h01);
      if (c == 1) pad_hit = 8'h20;
      cycle();
      pad_hit = '0;
    end
    chk("hold_missed", {24'd0, missed_count}, 32'd1);
    trig_ready = 1'b1;
    cycle();
    chk("hold_xfer_valid", {31'd0, trig_valid}, 32'd0);
    chk("hold_xfer_count", {16'd0, trig_count}, 32'd1);
    repeat (10) cycle();
    chk("hold_single", {16'd0, trig_count}, 32'd1);

    // Deadtime: coincidence inside DEAD is missed, after DEAD it triggers
    do_reset();
    enable = 1'b1; coinc_window = 4'd2; majority = 4'd1; deadtime = 8'd20; trig_ready = 1'b1;
    repeat (3) cycle();
    pad_hit = 8'h01; cycle(); pad_hit = '0;
    repeat (3) cycle();
    chk("dead_first_valid", {31'd0, trig_valid}, 32'd1);
    cycle();
    chk("dead_count1", {16'd0, trig_count}, 32'd1);
    chk("dead_busy", {31'd0, busy}, 32'd1);
    repeat (9) cycle();
    pad_hit = 8'h02; cycle(); pad_hit = '0;
    for (int c = 0; c < 14; c++) begin
      cycle();
      chk("dead_no_trig", {31'd0, trig_valid}, 32'd0);
    end
    chk("dead_missed", {24'd0, missed_count}, 32'd1);
    chk("dead_rearmed", {31'd0, busy}, 32'd0);
    pad_hit = 8'h04; cycle(); pad_hit = '0;
    repeat (3) cycle();
    chk("dead_second_valid", {31'd0, trig_valid}, 32'd1);
    chk("dead_second_bcid", {20'd0, trig_bcid}, 32'd32);
    chk("dead_second_mask", {24'd0, trig_layer_mask}, 32'h04);

    // Enable dropped while holding a record
    do_reset();
    enable = 1'b1; coinc_window = 4'd4; majority = 4'd1; deadtime = 8'd0; trig_ready = 1'b0;
    repeat (2) cycle();
    pad_hit = 8'h40; cycle(); pad_hit = '0;
    repeat (4) cycle();
    chk("en_hold_valid", {31'd0, trig_valid}, 32'd1);
    enable = 1'b0;
    cycle();
    chk("en_drop_valid", {31'd0, trig_valid}, 32'd0);
    chk("en_drop_count", {16'd0, trig_count}, 32'd0);
    enable = 1'b1; trig_ready = 1'b1;
    repeat (6) cycle();
    chk("en_no_retrig", {16'd0, trig_count}, 32'd0);

    // Asynchronous reset in the middle of DEAD
    do_reset();
    enable = 1'b1; coinc_window = 4'd1; majority = 4'd1; deadtime = 8'd20; trig_ready = 1'b1;
    repeat (2) cycle();
    pad_hit = 8'h02; cycle(); pad_hit = '0;
    repeat (7) cycle();
    chk("ar_busy", {31'd0, busy}, 32'd1);
    chk("ar_count", {16'd0, trig_count}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid0", {31'd0, trig_valid}, 32'd0);
    chk("ar_busy0", {31'd0, busy}, 32'd0);
    chk("ar_bcid0", {20'd0, trig_bcid}, 32'd0);
    chk("ar_mask0", {24'd0, trig_layer_mask}, 32'd0);
    chk("ar_count0", {16'd0, trig_count}, 32'd0);
    chk("ar_missed0", {24'd0, missed_count}, 32'd0);
    model_reset();

    // BCID wrap-around stamping
    do_reset();
    enable = 1'b1; coinc_window = 4'd1; majority = 4'd1; deadtime = 8'd0; trig_ready = 1'b1;
    repeat (4095) cycle();
    pad_hit = 8'h01; cycle(); pad_hit = '0;
    repeat (3) cycle();
    chk("wrap_valid", {31'd0, trig_valid}, 32'd1);
    chk("wrap_bcid_max", {20'd0, trig_bcid}, 32'd4095);
    repeat (2) cycle();
    pad_hit = 8'h02; cycle(); pad_hit = '0;
    repeat (3) cycle();
    chk("wrap_valid2", {31'd0, trig_valid}, 32'd1);
    chk("wrap_bcid_small", {20'd0, trig_bcid}, 32'd5);
    chk("wrap_mask2", {24'd0, trig_layer_mask}, 32'h02);
    cycle();
    chk("wrap_count", {16'd0, trig_count}, 32'd2);

    // Random stimulus against the model
    do_reset();
    enable = 1'b1; trig_ready = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        coinc_window = 4'($urandom_range(0, 15));
        majority     = 4'($urandom_range(0, 9));
        deadtime     = 8'($urandom_range(0, 25));
      end
      enable     = ($urandom_range(0, 99) != 0);
      trig_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NL; i++) pad_hit[i] = ($urandom_range(0, 9) == 0);
      cycle();
    end
    pad_hit = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
